// File: rtl/hamming_secded_stream.sv
`default_nettype none
// ============================================================================
// Module      : hamming_secded_stream
// Description : Two-stage streaming Hamming SECDED encode/inject/decode pipe.
//               Stage 1 registers encode(in_data) ^ inj_mask, stage 2 registers
//               the decode result. Valid/ready on both sides, one shared
//               advance condition, and saturating single/double error counters.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - input handshake
//               in_data, inj_mask   - payload and error-injection XOR mask
//               out_valid/out_ready - output handshake
//               out_data            - corrected payload
//               out_codeword        - received (post-injection) codeword
//               out_syndrome        - Hamming syndrome
//               out_err_single/out_err_double - error classification
//               cnt_clr             - synchronous clear of both counters
//               cnt_single/cnt_double - saturating error counters
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    // Smallest P with 2^P >= DATA_W+P+1 over the legal range 4..57.
    localparam int P     = (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 : 6,
    localparam int CW    = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW-1:0]     inj_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_codeword,
    output logic [P-1:0]      out_syndrome,
    output logic              out_err_single,
    output logic              out_err_double,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);

    // Position is a data slot when it is not a power of two (and not bit 0).
    function automatic logic f_is_data_pos(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) != 0);
    endfunction

    function automatic logic [CW-1:0] f_encode(input logic [DATA_W-1:0] d);
        logic [CW-1:0] c;
        int            j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (f_is_data_pos(pos)) begin
                c[pos] = d[j];
                j      = j + 1;
            end
        end
        for (int k = 0; k < P; k++) begin
            for (int pos = 1; pos < CW; pos++) begin
                if (f_is_data_pos(pos) && (((pos >> k) & 1) == 1)) begin
                    c[1 << k] = c[1 << k] ^ c[pos];
                end
            end
        end
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] f_extract(input logic [CW-1:0] c);
        logic [DATA_W-1:0] d;
        int                j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (f_is_data_pos(pos)) begin
                d[j] = c[pos];
                j    = j + 1;
            end
        end
        return d;
    endfunction

    logic              w_adv;
    logic [CW-1:0]     w_enc;
    logic              r_s1_valid;
    logic [CW-1:0]     r_s1_cw;
    logic [P-1:0]      w_syn;
    logic              w_par;
    logic              w_single;
    logic              w_double;
    logic [CW-1:0]     w_fix;
    logic [DATA_W-1:0] w_dec_data;

    // Both stages move together; a full stage 2 that is not being drained
    // freezes the whole pipe.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;
    assign w_enc    = f_encode(in_data);

    always_comb begin
        w_syn    = '0;
        w_par    = ^r_s1_cw;
        for (int pos = 1; pos < CW; pos++) begin
            if (r_s1_cw[pos]) begin
                w_syn = w_syn ^ P'(pos);
            end
        end
        // Odd overall parity with a syndrome that names a real position
        // (or zero, meaning bit 0 itself) is a correctable single error.
        w_single = w_par && (int'(w_syn) <= CW - 1);
        w_double = (w_syn != '0) && !w_single;
        w_fix    = r_s1_cw;
        for (int pos = 1; pos < CW; pos++) begin
            if (w_single && (int'(w_syn) == pos)) begin
                w_fix[pos] = ~r_s1_cw[pos];
            end
        end
        w_dec_data = f_extract(w_fix);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid     <= 1'b0;
            r_s1_cw        <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_codeword   <= '0;
            out_syndrome   <= '0;
            out_err_single <= 1'b0;
            out_err_double <= 1'b0;
        end else if (w_adv) begin
            // No accepted input leaves a bubble in stage 1.
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_cw <= w_enc ^ inj_mask;
            end
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data       <= w_dec_data;
                out_codeword   <= r_s1_cw;
                out_syndrome   <= w_syn;
                out_err_single <= w_single;
                out_err_double <= w_double;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (out_valid && out_ready) begin
            if (out_err_single && (cnt_single != {CNT_W{1'b1}})) begin
                cnt_single <= cnt_single + 1'b1;
            end
            if (out_err_double && (cnt_double != {CNT_W{1'b1}})) begin
                cnt_double <= cnt_double + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/hamming_secded_stream.md
HAMMING_SECDED_STREAM -- requirements
Module: hamming_secded_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width, legal range 4..57.
REQ-002 SHALL have parameter CNT_W, default 16: width of each error counter.
REQ-003 SHALL use derived constants: P = smallest integer with 2^P >= DATA_W+P+1; CW = DATA_W+P+1 (CW = 13 at default).
REQ-004 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: input word present.
REQ-007 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-008 SHALL have port in_data, input, DATA_W: payload to encode.
REQ-009 SHALL have port inj_mask, input, CW: error-injection XOR mask, sampled with in_data.
REQ-010 SHALL have port out_valid, output, 1: decoded result present.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-012 SHALL have port out_data, output, DATA_W: corrected payload.
REQ-013 SHALL have port out_codeword, output, CW: received (post-injection, uncorrected) codeword.
REQ-014 SHALL have port out_syndrome, output, P: Hamming syndrome.
REQ-015 SHALL have port out_err_single, output, 1: single-bit error detected and corrected.
REQ-016 SHALL have port out_err_double, output, 1: uncorrectable error detected.
REQ-017 SHALL have port cnt_clr, input, 1: synchronous clear of both counters.
REQ-018 SHALL have port cnt_single, output, CNT_W: saturating count of single-error results delivered.
REQ-019 SHALL have port cnt_double, output, CNT_W: saturating count of double-error results delivered.

Function
REQ-020 SHALL lay out the codeword as follows: bit 0 = overall parity; bits 1..CW-1 = Hamming positions; power-of-two positions hold parity; payload bits in order d0 upward fill the remaining positions, ascending.
REQ-021 SHALL set parity bit 2^k to the XOR of all data positions whose index has bit k set; bit 0 SHALL make the XOR of all CW bits equal 0.
REQ-022 SHALL use a two-stage pipeline: stage 1 registers encode(in_data) XOR inj_mask; stage 2 registers the decode results.
REQ-023 SHALL make out_valid rise exactly 2 cycles after an accepted input when out_ready is held high.
REQ-024 SHALL advance both stages only when the advance condition adv = out_ready OR NOT out_valid is true; stages hold all contents when adv is false.
REQ-025 SHALL drive in_ready = adv; an input is accepted on a cycle when in_valid AND in_ready.
REQ-026 SHALL mark an empty stage-1 slot invalid when adv is true and no input is accepted, creating a bubble with no data loss.
REQ-027 SHALL hold all out_* signals stable while out_valid AND NOT out_ready.
REQ-028 SHALL compute syndrome s = XOR of the indices of the set bits among positions 1..CW-1, and overall parity p = XOR of all CW bits.
REQ-029 SHALL decode s=0, p=0 as clean: both flags 0.
REQ-030 SHALL decode s≠0, p=1, s≤CW-1 as single: flip bit s, err_single=1.
REQ-031 SHALL decode s=0, p=1 as single in bit 0: data unchanged, err_single=1.
REQ-032 SHALL decode s≠0, p=0 as double: err_double=1, out_data = uncorrected extracted payload.
REQ-033 SHALL decode s≠0, p=1, s>CW-1 as double: err_double=1.
REQ-034 SHALL never assert err_single and err_double together.
REQ-035 SHALL increment each counter once per output handshake (out_valid AND out_ready) carrying its flag.
REQ-036 SHALL saturate each counter at 2^CNT_W-1 with no wrap.
REQ-037 SHALL give cnt_clr priority over a same-cycle increment: the counter reads 0 next cycle.
REQ-038 SHALL implement the datapath with no combinational path from in_* to out_*; in_ready SHALL depend combinationally only on out_ready and internal state.

Reset
REQ-039 SHALL, on rst high at a clock edge, clear both valid bits, out_data, out_codeword, out_syndrome, both flags and both counters to 0.
REQ-040 SHALL discard in-flight words on mid-operation reset; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-041 SHALL give rst priority over cnt_clr and all handshakes.

Verification
REQ-042 SHALL cover: DATA_W=8, in_data=0xA5, inj_mask=0, out_ready=1 -> 2 cycles later out_codeword=0x144E, out_data=0xA5, syndrome 0, flags 0.
REQ-043 SHALL cover: in_data=0xA5, inj_mask=0x0040 -> out_codeword=0x140E, syndrome 6, err_single=1, out_data=0xA5, cnt_single=1.
REQ-044 SHALL cover: in_data=0xA5, inj_mask=0x0041 -> syndrome 6, err_double=1, err_single=0, cnt_double=1; inj_mask=0x0001 -> syndrome 0, err_single=1, out_data=0xA5.
REQ-045 SHALL cover: stream 4 words with out_ready=0 for 5 cycles -> in_ready=0 once both stages are full; on release all 4 words emerge in order, none lost or duplicated.
REQ-046 SHALL cover: CNT_W=2, 5 single-error words -> cnt_single saturates at 3; cnt_clr pulsed coincident with a 6th single-error handshake -> cnt_single=0.
REQ-047 SHALL cover: rst asserted with 2 words in flight -> out_valid=0 and counters 0 the next cycle; no stale word ever appears afterwards.
